// File: rtl/arm_cond_pkg.sv
// arm_cond_pkg: shared constants for the ARM condition/flag path.
// Condition code encodings (instruction bits [31:28]), flag bit positions
// inside the {N,Z,C,V} flag vector, and FlagW write-enable bit positions.
package arm_cond_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // FlagW[1] enables the N,Z update; FlagW[0] enables the C,V update.
    localparam int FLAGW_NZ = 1;
    localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// cond_check: purely combinational evaluation of a 4-bit ARM condition
// field against the stored {N,Z,C,V} flags. The reserved code (NV) never
// passes.
module cond_check
    import arm_cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // Decode the condition field into the pass/fail decision.
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_flag_unit.sv
// cond_flag_unit: architectural flag register plus condition-gated,
// registered control outputs (PCSrc/RegWrite/MemWrite) for the writeback
// and PC path. Conditions are evaluated against the flags as they stand
// at the start of the cycle, so an instruction sees the flags written by
// its predecessor.
// Optional build macro: COND_STATS_EN adds saturating exec/squash counters.
module cond_flag_unit
    import arm_cond_pkg::*;
#(
    parameter logic [3:0] FLAG_RST = 4'b0000,
    parameter int         CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             stall,
    input  logic [3:0]       Cond,
    input  logic [1:0]       FlagW,
    input  logic [3:0]       ALUFlags,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    output logic             out_valid,
    output logic             CondEx,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
`ifdef COND_STATS_EN
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] squash_cnt,
`endif
    output logic [3:0]       Flags
);

    // Counters need at least a couple of bits to be meaningful; this also
    // keeps CNT_W referenced in builds without the statistics option.
    if (CNT_W < 2) begin : g_cnt_w_check
        $error("cond_flag_unit: CNT_W must be at least 2");
    end

    logic pass;
    logic accept;
    logic commit;

    cond_check u_cond_check (
        .cond  (Cond),
        .flags (Flags),
        .pass  (pass)
    );

    // accept: an instruction is actually consumed this cycle.
    assign accept = in_valid & ~stall;
    assign commit = accept & pass;

    // Flag register: only a committed instruction may update it, and the
    // two FlagW halves gate N,Z and C,V independently.
    always_ff @(posedge clk) begin
        if (reset) begin
            Flags <= FLAG_RST;
        end else if (commit) begin
            if (FlagW[FLAGW_NZ]) begin
                Flags[FLAG_N] <= ALUFlags[FLAG_N];
                Flags[FLAG_Z] <= ALUFlags[FLAG_Z];
            end
            if (FlagW[FLAGW_CV]) begin
                Flags[FLAG_C] <= ALUFlags[FLAG_C];
                Flags[FLAG_V] <= ALUFlags[FLAG_V];
            end
        end
    end

    // Output stage: one cycle of latency, holds during stall, a bubble
    // (in_valid low) clears every control output.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            CondEx    <= 1'b0;
            PCSrc     <= 1'b0;
            RegWrite  <= 1'b0;
            MemWrite  <= 1'b0;
        end else if (!stall) begin
            out_valid <= in_valid;
            CondEx    <= in_valid & pass;
            PCSrc     <= PCS  & in_valid & pass;
            RegWrite  <= RegW & in_valid & pass;
            MemWrite  <= MemW & in_valid & pass;
        end
    end

`ifdef COND_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Statistics: every accepted instruction bumps exactly one counter;
    // both stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            exec_cnt   <= '0;
            squash_cnt <= '0;
        end else if (accept) begin
            if (pass) begin
                if (exec_cnt != {CNT_W{1'b1}}) begin
                    exec_cnt <= exec_cnt + CNT_ONE;
                end
            end else begin
                if (squash_cnt != {CNT_W{1'b1}}) begin
                    squash_cnt <= squash_cnt + CNT_ONE;
                end
            end
        end
    end
`endif

endmodule
